// File: rtl/pi_fifo_arb.sv
// Two-requester packet arbiter in front of a byte FIFO, clocked on the falling edge of clk.
// Optional idle-lock timeout is built only when PI_FIFO_ARB_TMO_EN is defined.
module pi_fifo_arb #(
    parameter int FREE_MIN = 2,
    parameter int TMO_CYC  = 1024
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    input  logic [10:0] fifo_free,
    output logic        fifo_we,
    output logic [7:0]  fifo_di,
    output logic [1:0]  grant,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic        tmo_err
);
    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  GNT0 = 2'd1;
    localparam logic [1:0]  GNT1 = 2'd2;
    localparam logic [10:0] FREE_MIN_W = 11'(FREE_MIN);
    localparam logic [15:0] TMO_LIMIT  = 16'(TMO_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        fifo_we_q;
    logic [7:0]  fifo_di_q, fifo_di_d;
    logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [15:0] pkt_cnt1_q, pkt_cnt1_d;
    logic        space_ok, xfer0, xfer1, xfer, done0, done1, tmo_hit;

    assign space_ok   = (fifo_free >= FREE_MIN_W);
    assign req0_ready = (state_q == GNT0) & space_ok;
    assign req1_ready = (state_q == GNT1) & space_ok;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    assign xfer       = xfer0 | xfer1;
    assign done0      = xfer0 & req0_last;
    assign done1      = xfer1 & req1_last;

    assign grant    = {state_q == GNT1, state_q == GNT0};
    assign fifo_we  = fifo_we_q;
    assign fifo_di  = fifo_di_q;
    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                // last_gnt_q names the most recent owner, so the other side wins a tie
                if (req0_valid && req1_valid) state_d = last_gnt_q ? GNT0 : GNT1;
                else if (req0_valid)          state_d = GNT0;
                else if (req1_valid)          state_d = GNT1;
            end
            GNT0:    if (done0) state_d = IDLE;
            GNT1:    if (done1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
        if (state_q == IDLE && state_d == GNT0) last_gnt_d = 1'b0;
        if (state_q == IDLE && state_d == GNT1) last_gnt_d = 1'b1;
    end

    always_comb begin
        fifo_di_d  = fifo_di_q;
        if (xfer) fifo_di_d = xfer1 ? req1_data : req0_data;
        pkt_cnt0_d = pkt_cnt0_q + {15'd0, done0};
        pkt_cnt1_d = pkt_cnt1_q + {15'd0, done1};
    end

    always_ff @(negedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            fifo_we_q  <= 1'b0;
            fifo_di_q  <= 8'd0;
            pkt_cnt0_q <= 16'd0;
            pkt_cnt1_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            fifo_we_q  <= xfer;
            fifo_di_q  <= fifo_di_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

`ifdef PI_FIFO_ARB_TMO_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_err_q;
    logic        owner_stall;

    assign owner_stall = ((state_q == GNT0) & ~req0_valid) | ((state_q == GNT1) & ~req1_valid);
    assign tmo_hit     = owner_stall & (tmo_cnt_q == TMO_LIMIT);
    assign tmo_err     = tmo_err_q;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (xfer || state_d == IDLE) tmo_cnt_d = 16'd0;
        else if (owner_stall)        tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    always_ff @(negedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_cnt_q <= 16'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_q | tmo_hit;
        end
    end
`else
    logic tmo_unused;
    assign tmo_unused = ^TMO_LIMIT;
    assign tmo_hit    = 1'b0;
    assign tmo_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pi_fifo_arb.sv
// Scoreboard bench for pi_fifo_arb: DUT acts on negedge, bench drives and samples around posedge.
module tb_pi_fifo_arb;
    logic        clk = 1'b0;
    logic        sys_rst;
    logic        req0_valid, req0_last, req0_ready;
    logic        req1_valid, req1_last, req1_ready;
    logic [7:0]  req0_data, req1_data;
    logic [10:0] fifo_free;
    logic        fifo_we, tmo_err;
    logic [7:0]  fifo_di;
    logic [1:0]  grant;
    logic [15:0] pkt_cnt0, pkt_cnt1;

    int         n_cmp = 0;
    int         n_err = 0;
    int         wr_cnt = 0;
    int         cyc = 0;
    bit         sb_en = 1'b1;
    logic [7:0] exp_q[$];
    int         wr_cyc_q[$];

    always #5 clk = ~clk;

    pi_fifo_arb #(.FREE_MIN(2), .TMO_CYC(16)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .fifo_free(fifo_free), .fifo_we(fifo_we), .fifo_di(fifo_di), .grant(grant),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .tmo_err(tmo_err)
    );

    // Output monitor: every FIFO write is popped against the expected byte order
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            cyc++;
            if (fifo_we === 1'b1) begin
                wr_cnt++;
                wr_cyc_q.push_back(cyc);
                if (sb_en) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL wr_unexpected got %h required none", fifo_di);
                    end else begin
                        e = exp_q.pop_front();
                        if (fifo_di !== e) begin
                            n_err++;
                            $display("FAIL wr_data got %h required %h", fifo_di, e);
                        end else
                            $display("wr %h at cycle %0d", fifo_di, cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input int r, input logic v, input logic [7:0] d, input logic l);
        if (r == 0) begin req0_valid = v; req0_data = d; req0_last = l; end
        else        begin req1_valid = v; req1_data = d; req1_last = l; end
    endtask

    function automatic logic rdy(input int r);
        return (r == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic send_pkt(input int r, input logic [7:0] b [4], input int n);
        int i = 0;
        int c = 0;
        while (1) begin
            @(posedge clk);
            if (i == n) begin drive(r, 1'b0, 8'h00, 1'b0); break; end
            drive(r, 1'b1, b[i], i == n - 1);
            #1;
            if (rdy(r) === 1'b1) i++;
            c++;
            if (c > 300) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout req%0d got %0d bytes required %0d", r, i, n);
                drive(r, 1'b0, 8'h00, 1'b0);
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 20) begin @(posedge clk); #2; c++; end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain got %0d pending required 0", name, exp_q.size());
        end
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; fifo_free = 11'd100;
        drive(0, 1'b1, 8'hAA, 1'b0);
        drive(1, 1'b1, 8'hBB, 1'b0);
        @(posedge clk); #1;
        n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rst_grant got %b required 00", grant); end
        n_cmp++; if (fifo_we !== 1'b0 || fifo_di !== 8'h00) begin n_err++; $display("FAIL rst_fifo got we=%b di=%h required 0/00", fifo_we, fifo_di); end
        n_cmp++; if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0) begin n_err++; $display("FAIL rst_cnt got %h/%h required 0/0", pkt_cnt0, pkt_cnt1); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || tmo_err !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b%b tmo=%b required 00 tmo=0", req0_ready, req1_ready, tmo_err); end
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        fifo_free = 11'd100;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        send_pkt(0, '{8'h11, 8'h22, 8'h33, 8'h00}, 3);
        wait_drain("single");
        n = wr_cyc_q.size();
        n_cmp++; if (n < 3 || wr_cyc_q[n-1] - wr_cyc_q[n-3] != 2) begin n_err++; $display("FAIL single_consec got %0d writes not back-to-back required 3 consecutive", n); end
        n_cmp++; if (pkt_cnt0 !== 16'd1) begin n_err++; $display("FAIL single_cnt0 got %0d required 1", pkt_cnt0); end
        n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL single_grant got %b required 00", grant); end
    endtask

    task automatic test_round_robin();
        int n;
        apply_reset();
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
        fork
            send_pkt(0, '{8'hA1, 8'hA2, 8'h00, 8'h00}, 2);
            send_pkt(1, '{8'hB1, 8'hB2, 8'h00, 8'h00}, 2);
        join
        wait_drain("rr1");
        n = wr_cyc_q.size();
        n_cmp++; if (n < 4 || wr_cyc_q[n-2] - wr_cyc_q[n-3] != 2) begin n_err++; $display("FAIL rr_gap got %0d writes without single idle gap required gap 2", n); end
        n_cmp++; if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin n_err++; $display("FAIL rr_cnt got %0d/%0d required 1/1", pkt_cnt0, pkt_cnt1); end
        exp_q.push_back(8'hC0); exp_q.push_back(8'hD0);
        fork
            send_pkt(0, '{8'hC0, 8'h00, 8'h00, 8'h00}, 1);
            send_pkt(1, '{8'hD0, 8'h00, 8'h00, 8'h00}, 1);
        join
        wait_drain("rr2");
        n_cmp++; if (pkt_cnt0 !== 16'd2 || pkt_cnt1 !== 16'd2) begin n_err++; $display("FAIL rr2_cnt got %0d/%0d required 2/2", pkt_cnt0, pkt_cnt1); end
    endtask

    task automatic test_stall();
        int base, c;
        base = wr_cnt; c = 0;
        fifo_free = 11'd100;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h41 + 8'(k));
        fork
            send_pkt(0, '{8'h41, 8'h42, 8'h43, 8'h44}, 4);
            begin
                while (wr_cnt < base + 2 && c < 50) begin @(posedge clk); #2; c++; end
                @(posedge clk);
                fifo_free = 11'd1;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #2;
                    n_cmp++;
                    if (fifo_we !== 1'b0 || grant !== 2'b01) begin
                        n_err++;
                        $display("FAIL stall_hold got we=%b grant=%b required we=0 grant=01", fifo_we, grant);
                    end
                end
                @(posedge clk);
                fifo_free = 11'd50;
            end
        join
        wait_drain("stall");
        n_cmp++; if (pkt_cnt0 !== 16'd3) begin n_err++; $display("FAIL stall_cnt0 got %0d required 3", pkt_cnt0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [2];
        int i, c, base;
        b[0] = 8'h71; b[1] = 8'h72;
        i = 0; c = 0; base = wr_cnt;
        fifo_free = 11'd100;
        exp_q.push_back(8'h71); exp_q.push_back(8'h72);
        while (i < 2 && c < 50) begin
            @(posedge clk);
            drive(0, 1'b1, b[i], 1'b0);
            #1;
            if (req0_ready === 1'b1) i++;
            c++;
        end
        @(posedge clk);
        drive(0, 1'b1, 8'h73, 1'b0);
        #2 sys_rst = 1'b1;
        #1;
        n_cmp++; if (fifo_we !== 1'b0 || grant !== 2'b00 || req0_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_now got we=%b grant=%b rdy=%b required 0/00/0", fifo_we, grant, req0_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pkt_cnt0 !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt0 got %0d required 0", pkt_cnt0); end
        drive(0, 1'b0, 8'h00, 1'b0);
        sys_rst = 1'b0;
        repeat (3) @(posedge clk);
        n_cmp++; if (wr_cnt != base + 2 || exp_q.size() != 0) begin n_err++; $display("FAIL rstmid_writes got %0d required %0d", wr_cnt - base, 2); end
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h81 + 8'(k));
        send_pkt(0, '{8'h81, 8'h82, 8'h83, 8'h84}, 4);
        wait_drain("rstmid");
        n_cmp++; if (pkt_cnt0 !== 16'd1) begin n_err++; $display("FAIL rstmid_newcnt got %0d required 1", pkt_cnt0); end
    endtask

    task automatic test_wrap();
        int i = 0;
        int c = 0;
        apply_reset();
        fifo_free = 11'd100;
        sb_en = 1'b0;
        while (i < 65535 && c < 140000) begin
            @(posedge clk);
            drive(1, 1'b1, 8'(i), 1'b1);
            #1;
            if (req1_ready === 1'b1) i++;
            c++;
        end
        @(posedge clk);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        sb_en = 1'b1;
        n_cmp++; if (pkt_cnt1 !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre got %h required ffff", pkt_cnt1); end
        exp_q.push_back(8'hE5);
        send_pkt(1, '{8'hE5, 8'h00, 8'h00, 8'h00}, 1);
        wait_drain("wrap");
        n_cmp++; if (pkt_cnt1 !== 16'h0000 || pkt_cnt0 !== 16'h0000) begin n_err++; $display("FAIL wrap_cnt got %h/%h required 0000/0000", pkt_cnt1, pkt_cnt0); end
    endtask

`ifdef PI_FIFO_ARB_TMO_EN
    task automatic test_tmo();
        int k = 0;
        int c = 0;
        bit acc = 1'b0;
        apply_reset();
        fifo_free = 11'd100;
        exp_q.push_back(8'h51); exp_q.push_back(8'h61);
        fork
            begin
                while (!acc && c < 50) begin
                    @(posedge clk);
                    drive(0, 1'b1, 8'h51, 1'b0);
                    #1;
                    if (req0_ready === 1'b1) acc = 1'b1;
                    c++;
                end
                @(posedge clk);
                drive(0, 1'b0, 8'h00, 1'b0);
                do begin @(posedge clk); #1; k++; end while (grant === 2'b01 && k < 100);
                n_cmp++; if (k != 16) begin n_err++; $display("FAIL tmo_cycles got %0d required 16", k); end
                n_cmp++; if (tmo_err !== 1'b1 || pkt_cnt0 !== 16'd0) begin n_err++; $display("FAIL tmo_flag got tmo=%b cnt0=%0d required 1/0", tmo_err, pkt_cnt0); end
            end
            send_pkt(1, '{8'h61, 8'h00, 8'h00, 8'h00}, 1);
        join
        wait_drain("tmo");
        n_cmp++; if (pkt_cnt1 !== 16'd1 || tmo_err !== 1'b1) begin n_err++; $display("FAIL tmo_after got cnt1=%0d tmo=%b required 1/1", pkt_cnt1, tmo_err); end
    endtask
`else
    task automatic test_lock_hold();
        int c = 0;
        bit acc = 1'b0;
        apply_reset();
        fifo_free = 11'd100;
        exp_q.push_back(8'h91); exp_q.push_back(8'h92); exp_q.push_back(8'h99);
        fork
            begin
                while (!acc && c < 50) begin
                    @(posedge clk);
                    drive(0, 1'b1, 8'h91, 1'b0);
                    #1;
                    if (req0_ready === 1'b1) acc = 1'b1;
                    c++;
                end
                @(posedge clk);
                drive(0, 1'b0, 8'h00, 1'b0);
                repeat (40) @(posedge clk);
                #1;
                n_cmp++; if (grant !== 2'b01 || req1_ready !== 1'b0 || tmo_err !== 1'b0) begin n_err++; $display("FAIL lock_hold got grant=%b rdy1=%b tmo=%b required 01/0/0", grant, req1_ready, tmo_err); end
                send_pkt(0, '{8'h92, 8'h00, 8'h00, 8'h00}, 1);
            end
            send_pkt(1, '{8'h99, 8'h00, 8'h00, 8'h00}, 1);
        join
        wait_drain("lock");
        n_cmp++; if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin n_err++; $display("FAIL lock_cnt got %0d/%0d required 1/1", pkt_cnt0, pkt_cnt1); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
`ifdef PI_FIFO_ARB_TMO_EN
        test_tmo();
`else
        test_lock_hold();
`endif
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
